// File: rtl/alu_serial_sequencer_if.sv
// Word-level request/response bundle between a client and alu_serial_sequencer.
// The client drives start/op/a/b; the sequencer returns the handshake and result flags.
interface alu_serial_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, op, a, b,
    input  ready, done, result, zero, carry_out, overflow
  );

  modport slave (
    input  start, op, a, b,
    output ready, done, result, zero, carry_out, overflow
  );
endinterface

// File: rtl/alu_serial_sequencer.sv
// Bit-serial sequencer: walks a 1-bit ALU slice LSB-first over WIDTH cycles
// and assembles the word result plus zero/carry/overflow flags.
//
// state  | meaning
// IDLE   | ready=1, waiting for start; operands latched on accept
// RUN    | one slice evaluation per cycle, bit cnt_q presented to the slice
// DONE   | one-cycle done pulse; result/flags were loaded on entry
module alu_serial_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_serial_sequencer_if.slave bus,
  output logic                  slice_a,
  output logic                  slice_b,
  output logic                  slice_cin,
  output logic [3:0]            slice_op,
  input  logic                  slice_result,
  input  logic                  slice_cout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [3:0] SL_AND = 4'b0000;
  localparam logic [3:0] SL_OR  = 4'b0001;
  localparam logic [3:0] SL_ADD = 4'b0010;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [3:0]       op_q,     op_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] shreg_q,  shreg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q,   zero_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;

  logic             ainv, binv, force_zero, arith;
  logic [3:0]       sop;
  logic             bit_a, bit_b;
  logic             ovf_w;
  logic [WIDTH-1:0] shreg_nxt;
  logic [WIDTH-1:0] word_res;

  always_comb begin
    ainv       = 1'b0;
    binv       = 1'b0;
    force_zero = 1'b0;
    arith      = 1'b0;
    sop        = SL_AND;
    case (op_q)
      OP_AND: sop = SL_AND;
      OP_OR:  sop = SL_OR;
      OP_ADD: begin
        sop   = SL_ADD;
        arith = 1'b1;
      end
      OP_SUB, OP_SLT: begin
        sop   = SL_ADD;
        binv  = 1'b1;
        arith = 1'b1;
      end
      OP_NOR: begin
        sop  = SL_AND;
        ainv = 1'b1;
        binv = 1'b1;
      end
      default: force_zero = 1'b1;
    endcase
  end

  // Compare-based mux keeps the bit select in range for any CNT_W.
  always_comb begin
    bit_a = 1'b0;
    bit_b = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        bit_a = a_q[k];
        bit_b = b_q[k];
      end
    end
  end

  always_comb begin
    slice_a   = 1'b0;
    slice_b   = 1'b0;
    slice_cin = 1'b0;
    slice_op  = 4'b0000;
    if (state_q == S_RUN) begin
      slice_a   = (bit_a ^ ainv) & ~force_zero;
      slice_b   = (bit_b ^ binv) & ~force_zero;
      slice_cin = carry_q;
      slice_op  = sop;
    end
  end

  // On the MSB cycle carry_q is the carry into the MSB, slice_cout the carry out.
  always_comb begin
    ovf_w     = carry_q ^ slice_cout;
    shreg_nxt = {slice_result, shreg_q[WIDTH-1:1]};
    word_res  = shreg_nxt;
    if (op_q == OP_SLT) begin
      word_res    = '0;
      word_res[0] = slice_result ^ ovf_w;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    shreg_d  = shreg_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          cnt_d   = '0;
          carry_d = (bus.op == OP_SUB) || (bus.op == OP_SLT);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        shreg_d = shreg_nxt;
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          state_d  = S_DONE;
          result_d = word_res;
          zero_d   = (word_res == '0);
          cout_d   = arith & slice_cout;
          ovf_d    = arith & ovf_w;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      shreg_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      shreg_q  <= shreg_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.ready     = (state_q == S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Randomized scoreboard bench for alu_serial_sequencer with a behavioural
// 1-bit slice and a word-level reference model.
module tb_alu_serial_sequencer;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_serial_sequencer_if #(.WIDTH(WIDTH)) bus ();

  logic       slice_a, slice_b, slice_cin;
  logic [3:0] slice_op;
  logic       slice_result, slice_cout;

  always_comb begin
    slice_result = 1'b0;
    case (slice_op)
      4'b0000: slice_result = slice_a & slice_b;
      4'b0001: slice_result = slice_a | slice_b;
      4'b0010: slice_result = slice_a ^ slice_b ^ slice_cin;
      default: slice_result = 1'b0;
    endcase
  end
  assign slice_cout = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);

  alu_serial_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .slice_a      (slice_a),
    .slice_b      (slice_b),
    .slice_cin    (slice_cin),
    .slice_op     (slice_op),
    .slice_result (slice_result),
    .slice_cout   (slice_cout)
  );

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             c;
    logic             v;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int next_ok = 0;

  logic             act_on = 1'b0;
  int               act_k = 0;
  logic [3:0]       act_sop;
  logic [WIDTH-1:0] act_ea, act_eb;
  logic [WIDTH:0]   act_cv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void ref_op(input logic [3:0] op, input logic [WIDTH-1:0] a, b,
                                 output logic [WIDTH-1:0] res, output logic c, v);
    logic [WIDTH:0] s;
    res = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b1100: res = ~(a | b);
      4'b0010: begin
        s   = {1'b0, a} + {1'b0, b};
        res = s[WIDTH-1:0];
        c   = s[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110, 4'b0111: begin
        s   = {1'b0, a} + {1'b0, ~b} + 1;
        res = s[WIDTH-1:0];
        c   = s[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
        if (op == 4'b0111) res = ($signed(a) < $signed(b)) ? 1 : 0;
      end
      default: ;
    endcase
  endfunction

  function automatic void drive_of(input logic [3:0] op, input logic [WIDTH-1:0] a, b,
                                   output logic [3:0] sop, output logic [WIDTH-1:0] ea, eb,
                                   output logic [WIDTH:0] cv);
    logic           c0;
    logic [WIDTH:0] s;
    sop = 4'b0000; ea = '0; eb = '0; c0 = 1'b0;
    case (op)
      4'b0000: begin sop = 4'b0000; ea = a;  eb = b;  end
      4'b0001: begin sop = 4'b0001; ea = a;  eb = b;  end
      4'b0010: begin sop = 4'b0010; ea = a;  eb = b;  end
      4'b0110, 4'b0111: begin sop = 4'b0010; ea = a; eb = ~b; c0 = 1'b1; end
      4'b1100: begin sop = 4'b0000; ea = ~a; eb = ~b; end
      default: ;
    endcase
    // carry into bit j recovered from the full-width sum
    s  = {1'b0, ea} + {1'b0, eb} + {{WIDTH{1'b0}}, c0};
    cv = s ^ {1'b0, ea} ^ {1'b0, eb};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] a, b);
    exp_t e;
    int   k;
    @(negedge clk);
    while (cyc < next_ok - 1) @(negedge clk);
    chk("ready_at_issue", {31'b0, bus.ready}, 32'd1);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 4'($urandom);
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    k = cyc;
    ref_op(op, a, b, e.res, e.c, e.v);
    e.z   = (e.res == '0);
    e.cyc = k + WIDTH;
    q.push_back(e);
    drive_of(op, a, b, act_sop, act_ea, act_eb, act_cv);
    act_k   = k;
    act_on  = 1'b1;
    next_ok = k + WIDTH + 2;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      int   j;
      logic [6:0] exp_drv;
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", {31'b0, bus.done}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_latency", cyc, e.cyc);
          chk("result", {24'b0, bus.result}, {24'b0, e.res});
          chk("zero", {31'b0, bus.zero}, {31'b0, e.z});
          chk("carry_out", {31'b0, bus.carry_out}, {31'b0, e.c});
          chk("overflow", {31'b0, bus.overflow}, {31'b0, e.v});
        end
      end
      j = cyc - act_k;
      exp_drv = '0;
      if (act_on && j >= 0 && j < WIDTH)
        exp_drv = {act_sop, act_ea[j], act_eb[j], act_cv[j]};
      chk("slice_drive", {25'b0, slice_op, slice_a, slice_b, slice_cin}, {25'b0, exp_drv});
    end
  end

  initial begin
    int k0;
    int sel;
    logic [3:0] rop;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", {31'b0, bus.ready}, 32'd1);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_outputs", {20'b0, bus.result, bus.zero, bus.carry_out, bus.overflow}, 32'd0);
    chk("rst_slice", {25'b0, slice_op, slice_a, slice_b, slice_cin}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(4'b0010, 8'h7F, 8'h01);
    issue(4'b0110, 8'h05, 8'h05);
    issue(4'b0111, 8'h80, 8'h01);
    issue(4'b0111, 8'h01, 8'h80);
    issue(4'b1100, 8'hF0, 8'h0C);
    issue(4'b0000, 8'hF0, 8'h3C);
    issue(4'b0001, 8'hF0, 8'h0C);
    issue(4'b0101, 8'hAB, 8'hCD);

    // start pulse mid-run must be ignored
    issue(4'b0010, 8'h11, 8'h22);
    k0 = act_k;
    while (cyc < k0 + 3) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'b0001;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    @(posedge clk);
    #1 bus.start = 1'b0;

    // leave a non-zero result behind, then abort the next run with reset
    issue(4'b0001, 8'h5A, 8'h00);
    issue(4'b0010, 8'h33, 8'h44);
    k0 = act_k;
    while (cyc < k0 + 4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    q.delete();
    act_on = 1'b0;
    chk("abort_ready", {31'b0, bus.ready}, 32'd1);
    chk("abort_done", {31'b0, bus.done}, 32'd0);
    chk("abort_outputs", {20'b0, bus.result, bus.zero, bus.carry_out, bus.overflow}, 32'd0);
    chk("abort_slice", {25'b0, slice_op, slice_a, slice_b, slice_cin}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    next_ok = 0;
    repeat (WIDTH + 3) @(negedge clk);
    issue(4'b0010, 8'h10, 8'h20);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: rop = 4'b0000;
        1: rop = 4'b0001;
        2: rop = 4'b0010;
        3: rop = 4'b0110;
        4: rop = 4'b0111;
        5: rop = 4'b1100;
        default: rop = 4'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) next_ok = next_ok + $urandom_range(1, 4);
      issue(rop, WIDTH'($urandom), WIDTH'($urandom));
    end

    for (int t = 0; t < 4 * WIDTH && q.size() != 0; t++) @(negedge clk);
    chk("drain", q.size(), 32'd0);
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
